// File: rtl/instr_fetch.sv
// Instruction fetch front end. It drives the instr_mem address and consumes
// the registered read data one cycle later. It replays the in-flight address
// while decode stalls, and drops stale data when a redirect arrives.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_addr,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic [31:0] fault_pc, fault_pc_nxt;
  logic        pend, pend_nxt;
  logic        accept;

  // Decode-facing outputs and the address mux for instr_mem
  always_comb begin
    instr_valid  = pend && (state == RUN) && !redirect_valid;
    instr_pc     = req_pc;
    instr_out    = instr_valid ? instr_in : NOP;
    misalign_err = (state == FAULT);
    accept       = instr_valid && !stall;
    if (redirect_valid)
      pc_addr = redirect_pc;
    else if ((state == RUN) && pend && stall)
      pc_addr = req_pc;
    else if (state == FAULT)
      pc_addr = fault_pc;
    else
      pc_addr = fetch_pc;
  end

  // Next-state logic; redirect overrides stall and fetch_en in every state
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    fault_pc_nxt = fault_pc;
    pend_nxt     = pend;
    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        state_nxt    = RUN;
        req_pc_nxt   = redirect_pc;
        fetch_pc_nxt = redirect_pc + 32'd4;
        pend_nxt     = 1'b1;
      end else begin
        state_nxt    = FAULT;
        fault_pc_nxt = {redirect_pc[31:2], 2'b00};
        pend_nxt     = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en) begin
            state_nxt    = RUN;
            req_pc_nxt   = fetch_pc;
            fetch_pc_nxt = fetch_pc + 32'd4;
            pend_nxt     = 1'b1;
          end
        end
        RUN: begin
          // A stalled live word is held regardless of fetch_en; once it is
          // accepted (or nothing is live) fetch_en decides issue vs. idle.
          if (stall && pend) begin
            state_nxt = RUN;
          end else if (!fetch_en) begin
            state_nxt = IDLE;
            pend_nxt  = 1'b0;
          end else begin
            req_pc_nxt   = fetch_pc;
            fetch_pc_nxt = fetch_pc + 32'd4;
            pend_nxt     = 1'b1;
          end
        end
        FAULT: begin
          state_nxt = FAULT;
          pend_nxt  = 1'b0;
        end
        default: begin
          state_nxt = IDLE;
          pend_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      fault_pc <= RESET_PC;
      pend     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      fault_pc <= fault_pc_nxt;
      pend     <= pend_nxt;
    end
  end

  // Count of instructions accepted by decode, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (accept)
      fetch_count <= fetch_count + 32'd1;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a one-cycle registered memory model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_in;
  logic [31:0] pc_addr;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_in       (instr_in),
    .pc_addr        (pc_addr),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Memory with registered read data
  always @(posedge clk) instr_in <= mem_word(pc_addr);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (pc_addr !== 32'h0) begin fails++; $display("FAIL rst_pc_addr: got %h want %h", pc_addr, 32'h0); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    tests++; if (instr_out !== NOP) begin fails++; $display("FAIL rst_instr_out: got %h want %h", instr_out, NOP); end
    tests++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b want 0", misalign_err); end
    tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL rst_count: got %0d want 0", fetch_count); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    fetch_en = 1'b1;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL seq_idle_valid: got %b want 0", instr_valid); end
    tests++; if (pc_addr !== 32'h0) begin fails++; $display("FAIL seq_idle_addr: got %h want 0", pc_addr); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); end
      tests++; if (instr_pc !== 32'(4 * i)) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", i, instr_pc, 32'(4 * i)); end
      tests++; if (instr_out !== mem_word(32'(4 * i))) begin fails++; $display("FAIL seq_data[%0d]: got %h want %h", i, instr_out, mem_word(32'(4 * i))); end
      tests++; if (pc_addr !== 32'(4 * i + 4)) begin fails++; $display("FAIL seq_addr[%0d]: got %h want %h", i, pc_addr, 32'(4 * i + 4)); end
      tests++; if (fetch_count !== 32'(i)) begin fails++; $display("FAIL seq_count[%0d]: got %0d want %0d", i, fetch_count, i); end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin fails++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h want v=1 pc=8", i, instr_valid, instr_pc); end
      tests++; if (instr_out !== mem_word(32'h8)) begin fails++; $display("FAIL stall_data[%0d]: got %h want %h", i, instr_out, mem_word(32'h8)); end
      tests++; if (pc_addr !== 32'h8) begin fails++; $display("FAIL stall_addr[%0d]: got %h want 8", i, pc_addr); end
      tests++; if (fetch_count !== 32'd2) begin fails++; $display("FAIL stall_count[%0d]: got %0d want 2", i, fetch_count); end
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || pc_addr !== 32'hC) begin fails++; $display("FAIL stall_release: got v=%b pc=%h addr=%h want v=1 pc=8 addr=c", instr_valid, instr_pc, pc_addr); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_pc !== 32'hC || instr_out !== mem_word(32'hC)) begin fails++; $display("FAIL stall_next: got pc=%h data=%h want pc=c data=%h", instr_pc, instr_out, mem_word(32'hC)); end
    tests++; if (fetch_count !== 32'd3) begin fails++; $display("FAIL stall_next_count: got %0d want 3", fetch_count); end
    next_cycle();
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || instr_out !== NOP) begin fails++; $display("FAIL redir_bubble: got v=%b data=%h want v=0 data=%h", instr_valid, instr_out, NOP); end
    tests++; if (pc_addr !== 32'h100) begin fails++; $display("FAIL redir_addr: got %h want 100", pc_addr); end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== mem_word(32'h100)) begin fails++; $display("FAIL redir_target: got v=%b pc=%h data=%h want v=1 pc=100", instr_valid, instr_pc, instr_out); end
    tests++; if (fetch_count !== 32'd4) begin fails++; $display("FAIL redir_count: got %0d want 4", fetch_count); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_pc !== 32'h104 || fetch_count !== 32'd5) begin fails++; $display("FAIL redir_seq: got pc=%h cnt=%0d want pc=104 cnt=5", instr_pc, fetch_count); end
    next_cycle();
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || pc_addr !== 32'h102) begin fails++; $display("FAIL fault_entry: got v=%b addr=%h want v=0 addr=102", instr_valid, pc_addr); end
    next_cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      @(negedge clk);
      tests++; if (misalign_err !== 1'b1) begin fails++; $display("FAIL fault_flag[%0d]: got %b want 1", i, misalign_err); end
      tests++; if (instr_valid !== 1'b0 || instr_out !== NOP) begin fails++; $display("FAIL fault_valid[%0d]: got v=%b data=%h want v=0 nop", i, instr_valid, instr_out); end
      tests++; if (pc_addr !== 32'h100 || fetch_count !== 32'd6) begin fails++; $display("FAIL fault_addr[%0d]: got addr=%h cnt=%0d want addr=100 cnt=6", i, pc_addr, fetch_count); end
      next_cycle();
    end
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    tests++; if (misalign_err !== 1'b1 || pc_addr !== 32'h200 || instr_valid !== 1'b0) begin fails++; $display("FAIL fault_exit: got err=%b addr=%h v=%b want err=1 addr=200 v=0", misalign_err, pc_addr, instr_valid); end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr_out !== mem_word(32'h200)) begin fails++; $display("FAIL fault_resume: got v=%b pc=%h data=%h want v=1 pc=200", instr_valid, instr_pc, instr_out); end
    tests++; if (misalign_err !== 1'b0 || fetch_count !== 32'd6) begin fails++; $display("FAIL fault_resume_state: got err=%b cnt=%0d want err=0 cnt=6", misalign_err, fetch_count); end
    next_cycle();
  endtask

  task automatic test_fetch_en();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h18;
    @(negedge clk);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    tests++; if (instr_pc !== 32'h18 || fetch_count !== 32'd7) begin fails++; $display("FAIL fen_pre: got pc=%h cnt=%0d want pc=18 cnt=7", instr_pc, fetch_count); end
    next_cycle();
    fetch_en = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1C || pc_addr !== 32'h20) begin fails++; $display("FAIL fen_drop: got v=%b pc=%h addr=%h want v=1 pc=1c addr=20", instr_valid, instr_pc, pc_addr); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (instr_valid !== 1'b0 || instr_out !== NOP || pc_addr !== 32'h20) begin fails++; $display("FAIL fen_idle[%0d]: got v=%b data=%h addr=%h want v=0 nop addr=20", i, instr_valid, instr_out, pc_addr); end
      tests++; if (fetch_count !== 32'd9) begin fails++; $display("FAIL fen_idle_count[%0d]: got %0d want 9", i, fetch_count); end
      next_cycle();
    end
    fetch_en = 1'b1;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fen_resume_bubble: got %b want 0", instr_valid); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr_out !== mem_word(32'h20)) begin fails++; $display("FAIL fen_resume: got v=%b pc=%h data=%h want v=1 pc=20", instr_valid, instr_pc, instr_out); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_pc !== 32'h24 || fetch_count !== 32'd10) begin fails++; $display("FAIL fen_resume_next: got pc=%h cnt=%0d want pc=24 cnt=10", instr_pc, fetch_count); end
    next_cycle();
    fetch_en = 1'b0;
    stall    = 1'b1;
    @(negedge clk);
    tests++; if (instr_pc !== 32'h28 || pc_addr !== 32'h28) begin fails++; $display("FAIL fen_stall: got pc=%h addr=%h want pc=28 addr=28", instr_pc, pc_addr); end
    next_cycle();
    fetch_en = 1'b1;
    stall    = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h28 || fetch_count !== 32'd11) begin fails++; $display("FAIL fen_stall_replay: got v=%b pc=%h cnt=%0d want v=1 pc=28 cnt=11", instr_valid, instr_pc, fetch_count); end
    next_cycle();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || pc_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_redir: got v=%b addr=%h want v=0 addr=fffffffc", instr_valid, pc_addr); end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    tests++; if (instr_pc !== 32'hFFFF_FFFC || instr_out !== mem_word(32'hFFFF_FFFC) || pc_addr !== 32'h0) begin fails++; $display("FAIL wrap_top: got pc=%h data=%h addr=%h want pc=fffffffc addr=0", instr_pc, instr_out, pc_addr); end
    tests++; if (fetch_count !== 32'd12) begin fails++; $display("FAIL wrap_count: got %0d want 12", fetch_count); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== mem_word(32'h0)) begin fails++; $display("FAIL wrap_zero: got v=%b pc=%h data=%h want v=1 pc=0", instr_valid, instr_pc, instr_out); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (pc_addr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL mid_rst_pc: got addr=%h pc=%h want 0 0", pc_addr, instr_pc); end
    tests++; if (instr_valid !== 1'b0 || instr_out !== NOP) begin fails++; $display("FAIL mid_rst_out: got v=%b data=%h want v=0 nop", instr_valid, instr_out); end
    tests++; if (fetch_count !== 32'h0 || misalign_err !== 1'b0) begin fails++; $display("FAIL mid_rst_state: got cnt=%0d err=%b want 0 0", fetch_count, misalign_err); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || pc_addr !== 32'h0) begin fails++; $display("FAIL mid_rst_idle: got v=%b addr=%h want v=0 addr=0", instr_valid, pc_addr); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== mem_word(32'h0)) begin fails++; $display("FAIL mid_rst_first: got v=%b pc=%h data=%h want v=1 pc=0", instr_valid, instr_pc, instr_out); end
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    tests++; if (misalign_err !== 1'b1 || pc_addr !== 32'h4) begin fails++; $display("FAIL fault_rst_pre: got err=%b addr=%h want err=1 addr=4", misalign_err, pc_addr); end
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (misalign_err !== 1'b0 || pc_addr !== 32'h0 || instr_valid !== 1'b0) begin fails++; $display("FAIL fault_rst: got err=%b addr=%h v=%b want 0 0 0", misalign_err, pc_addr, instr_valid); end
    next_cycle();
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault();
    test_fetch_en();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
